// File: rtl/io_timer_pkg.sv
// Shared definitions for the io_timer peripheral: register offsets, bit
// positions and the prescaler divisor table.
package io_timer_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_COMPARE = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CTC    = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_PS_LSB = 3;
  localparam int CTRL_PS_MSB = 5;
  localparam int CTRL_WIDTH  = 6;

  localparam int STATUS_MATCH = 0;
  localparam int STATUS_OVF   = 1;

  localparam logic [7:0] COMPARE_RESET = 8'hFF;

  typedef enum logic [2:0] {
    PS_DIV1    = 3'd0,
    PS_DIV8    = 3'd1,
    PS_DIV64   = 3'd2,
    PS_DIV256  = 3'd3,
    PS_DIV1024 = 3'd4
  } ps_e;

  // Terminal value of the prescaler counter (divisor - 1) for each encoding.
  function automatic logic [9:0] psTerminal(input logic [2:0] ps);
    case (ps)
      PS_DIV1:    return 10'd0;
      PS_DIV8:    return 10'd7;
      PS_DIV64:   return 10'd63;
      PS_DIV256:  return 10'd255;
      PS_DIV1024: return 10'd1023;
      default:    return 10'd0;
    endcase
  endfunction

  // Encodings above /1024 stop the timer entirely.
  function automatic logic psRunning(input logic [2:0] ps);
    return (ps <= 3'(PS_DIV1024));
  endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// 10-bit prescaler producing a one-cycle tick every divisor clocks while
// enabled; cleared by reset, by en=0 and by the clr strobe.
module io_timer_prescaler
  import io_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] ps,
  output logic       tick
);

  logic [9:0] r_cnt;
  logic [9:0] w_terminal;
  logic       w_running;
  logic       w_atTerminal;

  assign w_terminal   = psTerminal(ps);
  assign w_running    = psRunning(ps);
  assign w_atTerminal = (r_cnt == w_terminal);
  assign tick         = en && w_running && w_atTerminal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 10'd0;
    end else if (clr || !en || !w_running || w_atTerminal) begin
      r_cnt <= 10'd0;
    end else begin
      r_cnt <= r_cnt + 10'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 8-bit timer/counter with compare match, overflow and a level
// interrupt. Optional PWM output is built when IO_TIMER_PWM_EN is defined.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  output logic        irq
`ifdef IO_TIMER_PWM_EN
  ,
  output logic        pwm_out
`endif
);

  logic                  w_sel;
  logic [1:0]            w_off;
  logic                  w_wrCtrl;
  logic                  w_wrStatus;
  logic                  w_wrCount;
  logic                  w_wrCompare;
  logic                  w_tick;
  logic                  w_matchSet;
  logic                  w_ovfSet;
  logic [7:0]            w_countNext;
  logic [7:0]            w_rdData;

  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic                  r_match;
  logic                  r_ovf;
  logic [7:0]            r_count;
  logic [7:0]            r_compare;
  logic [7:0]            r_dout;
  logic                  r_irq;

  assign w_sel       = (addr[15:2] == BASE_ADDR[15:2]);
  assign w_off       = addr[1:0];
  assign w_wrCtrl    = w_en && w_sel && (w_off == REG_CTRL);
  assign w_wrStatus  = w_en && w_sel && (w_off == REG_STATUS);
  assign w_wrCount   = w_en && w_sel && (w_off == REG_COUNT);
  assign w_wrCompare = w_en && w_sel && (w_off == REG_COMPARE);

  io_timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (r_ctrl[CTRL_EN]),
    .clr  (w_wrCtrl),
    .ps   (r_ctrl[CTRL_PS_MSB:CTRL_PS_LSB]),
    .tick (w_tick)
  );

  // A CPU load of COUNT overrides the tick, including its flag effects.
  always_comb begin
    w_countNext = r_count;
    w_matchSet  = 1'b0;
    w_ovfSet    = 1'b0;
    if (w_wrCount) begin
      w_countNext = din;
    end else if (w_tick) begin
      if (r_count == r_compare) begin
        w_matchSet  = 1'b1;
        w_countNext = r_ctrl[CTRL_CTC] ? 8'd0 : r_count + 8'd1;
      end else if (r_count == 8'hFF) begin
        w_ovfSet    = 1'b1;
        w_countNext = 8'd0;
      end else begin
        w_countNext = r_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_rdData = 8'd0;
    case (w_off)
      REG_CTRL:    w_rdData = {2'b00, r_ctrl};
      REG_STATUS:  w_rdData = {6'd0, r_ovf, r_match};
      REG_COUNT:   w_rdData = r_count;
      REG_COMPARE: w_rdData = r_compare;
      default:     w_rdData = 8'd0;
    endcase
  end

  // A hardware flag set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_match   <= 1'b0;
      r_ovf     <= 1'b0;
      r_count   <= 8'd0;
      r_compare <= COMPARE_RESET;
      r_dout    <= 8'd0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wrCtrl) begin
        r_ctrl <= din[CTRL_WIDTH-1:0];
      end
      if (w_wrCompare) begin
        r_compare <= din;
      end
      r_count <= w_countNext;
      r_match <= w_matchSet | (r_match & ~(w_wrStatus & din[STATUS_MATCH]));
      r_ovf   <= w_ovfSet   | (r_ovf   & ~(w_wrStatus & din[STATUS_OVF]));
      r_dout  <= (r_en && w_sel) ? w_rdData : 8'd0;
      r_irq   <= r_ctrl[CTRL_IE] & (r_match | r_ovf);
    end
  end

  assign dout = r_dout;
  assign irq  = r_irq;

`ifdef IO_TIMER_PWM_EN
  logic r_pwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= r_ctrl[CTRL_EN] & (r_count < r_compare);
    end
  end

  assign pwm_out = r_pwm;
`endif

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped 8-bit timer/counter peripheral.
- Acts as a responder on the CPU data/IO bus, the same bus the data RAM answers on, and drives one CPU interrupt line.
- Provides a prescaled counter, a compare match, an overflow, and a level interrupt.
- Read data is registered with 1-cycle latency, matching the data RAM, so both can share the CPU read path.

Parameters:
- BASE_ADDR, 16'hFF00, base of the 4-byte register window; must be 4-aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- addr  in  16  data/IO bus address
- din  in  8  write data from the CPU
- w_en  in  1  write strobe
- r_en  in  1  read strobe
- dout  out  8  registered read data; 0 when not selected
- irq  out  1  level interrupt to the CPU interrupt input
- pwm_out  out  1  present only with IO_TIMER_PWM_EN

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Select: sel = (addr[15:2] == BASE_ADDR[15:2]). Register offset = addr[1:0].
- Register map (reserved bits read 0, writes to them are ignored):
  - 0 CTRL (rw): bit0 EN; bit1 CTC (clear on match); bit2 IE (irq enable); bits5:3 PS.
  - 1 STATUS (r, write-1-to-clear): bit0 MATCH; bit1 OVF.
  - 2 COUNT (rw): current count. A write loads the count.
  - 3 COMPARE (rw).
- Prescaler (PS encodings): 0 → /1, 1 → /8, 2 → /64, 3 → /256, 4 → /1024, 5..7 → stopped (no ticks).
  - 10-bit prescaler counter. It emits a 1-cycle tick when it reaches divisor-1, then returns to 0.
  - The counter is held at 0 while EN=0, and is reset to 0 on any CTRL write.
- On each tick:
  - If COUNT == COMPARE: set MATCH. If CTC=1, next COUNT = 0; otherwise COUNT+1.
  - Else if COUNT == 255: set OVF, COUNT = 0 (mod-256 wrap).
  - Else: COUNT+1.
  - With CTC=1 and COMPARE=255, MATCH is set and OVF is not.
- Simultaneous events:
  - CPU write to COUNT in the same cycle as a tick: the write wins and that tick has no flag effect.
  - Flag set and write-1-clear of the same bit in the same cycle: the set wins.
- Reads:
  - When r_en && sel, dout is the selected register on the next clock edge.
  - Otherwise dout = 0 on the next edge.
  - Reads have no side effects.
  - r_en and w_en both asserted: the write is performed and dout returns the pre-write value.
- Interrupt: irq = IE & (MATCH | OVF), registered. It rises 1 cycle after the flag sets and stays high until software clears the flag or IE=0.
- Reset values: CTRL=0, STATUS=0, COUNT=0, COMPARE=8'hFF, prescaler=0, dout=0, irq=0, pwm_out=0. A reset mid-count aborts the count immediately.
- Latency: a write takes effect in the cycle after the strobe. With PS=0, the first tick occurs 1 cycle after EN is set.

Optional Feature:
- Macro IO_TIMER_PWM_EN.
- With the macro: pwm_out port exists, registered, pwm_out = EN & (COUNT < COMPARE). COMPARE=0 gives constant 0.
- Without the macro: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package io_timer_pkg holds:
  - register offsets REG_CTRL / REG_STATUS / REG_COUNT / REG_COMPARE;
  - CTRL and STATUS bit indices;
  - PS encodings and the divisor table.
- One sub-module, io_timer_prescaler:
  - inputs clk, rst, en, clr, ps[2:0];
  - output tick;
  - contains the 10-bit counter.

Test Plan:
1. Reset, then read offsets 0..3 → dout 00, 00, 00, FF, each valid one cycle after r_en; read of BASE_ADDR+4 → dout 0.
2. COMPARE=5, CTRL=0x07 (EN, CTC, IE, PS=/1) → COUNT sequence 0,1..5,0. MATCH sets on the tick at COUNT=5. irq goes high the next cycle and stays high. Write STATUS=0x01 → irq low the following cycle.
3. CTRL=0x01, COUNT=0xFE → after 2 ticks COUNT=0x00 and OVF=1. irq stays 0 because IE=0. Setting IE → irq=1.
4. PS=1 (/8), EN=1 → COUNT increments exactly every 8 clocks. A CTRL rewrite mid-period restarts the 8-clock period. PS=5 → COUNT frozen.
5. Collisions: write COUNT=0x10 in the same cycle as a tick at COUNT==COMPARE → COUNT=0x10, MATCH unchanged. Write-1-clear of MATCH in the same cycle a new match sets it → MATCH stays 1.
6. With IO_TIMER_PWM_EN: COMPARE=3, CTC=0, PS=/1 → pwm_out high for COUNT 0..2 and low for 3..255 (period 256). rst asserted mid-run → pwm_out=0 and COUNT=0 the next cycle.
